// File: rtl/mont_exit.sv
// ============================================================================
// Module      : mont_exit
// Description : Bit-serial Montgomery reduction (REDC), y = a * 2^-W mod n.
//               Converts an operand out of the Montgomery domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_exit #(
    parameter int W = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] n,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int              c_cnt_w = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [W:0]         r_acc,   w_acc;
    logic [W-1:0]       r_n,     w_n;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt;
    logic [W-1:0]       r_y,     w_y;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;
    logic               r_err,   w_err;

    // acc stays below 2^W, so acc + n always fits in W+1 bits
    logic [W:0]         w_sum;
    logic [W-1:0]       w_sub;

    assign w_sum = r_acc + {1'b0, r_n};
    assign w_sub = r_acc[W-1:0] - r_n;

    always_comb begin
        w_state = r_state;
        w_acc   = r_acc;
        w_n     = r_n;
        w_cnt   = r_cnt;
        w_y     = r_y;
        w_busy  = r_busy;
        w_done  = r_done;
        w_err   = r_err;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    if (n[0]) begin
                        w_acc   = {1'b0, a};
                        w_n     = n;
                        w_cnt   = '0;
                        w_done  = 1'b0;
                        w_err   = 1'b0;
                        w_busy  = 1'b1;
                        w_state = S_SHIFT;
                    end else begin
                        // even modulus has no inverse of 2; reject at once
                        w_y    = '0;
                        w_done = 1'b1;
                        w_err  = 1'b1;
                        w_busy = 1'b0;
                    end
                end
            end
            S_SHIFT: begin
                w_acc = r_acc[0] ? (w_sum >> 1) : (r_acc >> 1);
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state = S_FIX;
                end
            end
            S_FIX: begin
                // REDC output is at most n, so a single subtract normalises it
                w_y     = (r_acc >= {1'b0, r_n}) ? w_sub : r_acc[W-1:0];
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_n    <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_acc  <= w_acc;
            r_n    <= w_n;
            r_cnt  <= w_cnt;
            r_y    <= w_y;
            r_busy <= w_busy;
            r_done <= w_done;
            r_err  <= w_err;
        end
    end

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mont_exit.sv
// ============================================================================
// Module      : tb_mont_exit
// Description : Directed self-checking bench for mont_exit at W=8, n=13/12.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mont_exit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic [W-1:0] a;
    logic [W-1:0] n;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    mont_exit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .a     (a),
        .n     (n),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a conversion, optionally pulse go mid-run with junk operands,
    // then wait for done and check latency, busy length and result.
    task automatic run(input logic [W-1:0] av, input logic [W-1:0] nv,
                       input logic [W-1:0] ey, input string tag, input int inject);
        int lat;
        int bcnt;
        a  = av;
        n  = nv;
        go = 1'b1;
        step();
        go = 1'b0;
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_clr"},   {31'd0, done}, 32'd0);
        chk({tag, "_err_clr"},    {31'd0, err},  32'd0);
        lat  = 0;
        bcnt = 1;
        while (!done && lat < 40) begin
            if (inject > 0 && lat == inject - 1) begin
                go = 1'b1;
                a  = 8'h55;
                n  = 8'd12;
            end else begin
                go = 1'b0;
                a  = av;
                n  = nv;
            end
            step();
            lat++;
            if (busy) bcnt++;
        end
        go = 1'b0;
        chk({tag, "_latency"}, lat, 32'd9);
        chk({tag, "_busy_len"}, bcnt, 32'd9);
        chk({tag, "_y"}, {24'd0, y}, {24'd0, ey});
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0;
        go    = 1'b0;
        a     = '0;
        n     = '0;
        #12;
        chk("rst_y",    {24'd0, y},    32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err",  {31'd0, err},  32'd0);
        rst_n = 1'b1;
        step();

        // 2^-8 mod 13 = 3
        run(8'd1,   8'd13, 8'd3,  "a1",   0);
        run(8'd0,   8'd13, 8'd0,  "a0",   0);
        run(8'd9,   8'd13, 8'd1,  "a9",   0);
        run(8'd13,  8'd13, 8'd0,  "a13",  0);
        run(8'd255, 8'd13, 8'd11, "a255", 0);

        // Even modulus: immediate rejection, y forced to 0
        a  = 8'd5;
        n  = 8'd12;
        go = 1'b1;
        step();
        go = 1'b0;
        chk("even_done", {31'd0, done}, 32'd1);
        chk("even_err",  {31'd0, err},  32'd1);
        chk("even_y",    {24'd0, y},    32'd0);
        chk("even_busy", {31'd0, busy}, 32'd0);
        run(8'd9, 8'd13, 8'd1, "after_even", 0);

        // go pulsed mid-run with changed operands is ignored
        run(8'd1, 8'd13, 8'd3, "ignore_go", 4);

        // Back-to-back: go issued in the cycle done is first seen
        a  = 8'd9;
        n  = 8'd13;
        go = 1'b1;
        step();
        go = 1'b0;
        chk("b2b_done_clr", {31'd0, done}, 32'd0);
        chk("b2b_busy",     {31'd0, busy}, 32'd1);
        chk("b2b_y_hold",   {24'd0, y},    32'd3);
        lat = 1;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("b2b_interval", lat, 32'd10);
        chk("b2b_y",        {24'd0, y}, 32'd1);

        // Asynchronous reset mid-SHIFT aborts without a done
        a  = 8'd1;
        n  = 8'd13;
        go = 1'b1;
        step();
        go = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort_y",    {24'd0, y},    32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        run(8'd255, 8'd13, 8'd11, "post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
